// File: rtl/zoom_ctrl_unit.sv
// ---------------------------------------------------------------------------
// zoom_ctrl_unit
//
// Purpose:
//   Instruction sequencer for the image-zoom coprocessor. It takes one 3-bit
//   instruction per enable/done handshake and does one of the following:
//   - performs a LOAD or STORE on the image memory;
//   - launches one of the four zoom engines (VP, RP, MP, VD) and tracks the
//     zoom level within [ZOOM_MIN, ZOOM_MAX];
//   - resets the zoom level.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   instruction[2:0]    000 NOP, 001 LOAD, 010 STORE, 011 ZOOM_IN_VP,
//                       100 ZOOM_IN_RP, 101 ZOOM_OUT_MP, 110 ZOOM_OUT_VD,
//                       111 RESET
//   enable              host request (level)
//   addr_in, data_in    host address / write data, latched on accept
//   data_out            last LOAD result, held until the next LOAD
//   flag_done           request complete, held until enable drops
//   flag_error          request rejected (valid while flag_done is high)
//   busy                controller is not idle
//   current_zoom        current zoom level
//   mem_addr, mem_wdata memory address / write data
//   mem_wr              one-cycle memory write strobe
//   mem_rdata           memory read data, MEM_LATENCY cycles after mem_addr
//   alg_sel[3:0]        one-hot engine select {VD,MP,RP,VP}
//   alg_start           one-cycle engine launch pulse
//   alg_done            engine completion pulse
//   display_valid       memory contents may be shown on the VGA
//
// Build option:
//   ZOOM_CTRL_WATCHDOG_EN  Aborts an engine run with flag_error if alg_done
//                          has not arrived 65535 cycles after alg_start.
// ---------------------------------------------------------------------------
module zoom_ctrl_unit #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int ZOOM_WIDTH  = 3,
  parameter int ZOOM_MIN    = 1,
  parameter int ZOOM_MAX    = 7,
  parameter int ZOOM_RESET  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            instruction,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  flag_done,
  output logic                  flag_error,
  output logic                  busy,
  output logic [ZOOM_WIDTH-1:0] current_zoom,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [3:0]            alg_sel,
  output logic                  alg_start,
  input  logic                  alg_done,
  output logic                  display_valid
);

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_LOAD     = 3'b001;
  localparam logic [2:0] OP_STORE    = 3'b010;
  localparam logic [2:0] OP_ZIN_VP   = 3'b011;
  localparam logic [2:0] OP_ZIN_RP   = 3'b100;
  localparam logic [2:0] OP_ZOUT_MP  = 3'b101;
  localparam logic [2:0] OP_ZOUT_VD  = 3'b110;
  localparam logic [2:0] OP_RESET    = 3'b111;

  // Wide enough to hold the value MEM_LATENCY itself.
  localparam int LAT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  localparam logic [ZOOM_WIDTH-1:0] Z_MIN = ZOOM_WIDTH'(ZOOM_MIN);
  localparam logic [ZOOM_WIDTH-1:0] Z_MAX = ZOOM_WIDTH'(ZOOM_MAX);
  localparam logic [ZOOM_WIDTH-1:0] Z_RST = ZOOM_WIDTH'(ZOOM_RESET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_ALG,
    S_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [ZOOM_WIDTH-1:0]   zoom_q, zoom_d;
  logic                    disp_q, disp_d;
  logic [3:0]              sel_q, sel_d;
  logic                    first_q, first_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
`ifdef ZOOM_CTRL_WATCHDOG_EN
  logic [15:0]             wdog_q, wdog_d;
`endif

  logic zoomInOp;
  assign zoomInOp = (instr_q == OP_ZIN_VP) || (instr_q == OP_ZIN_RP);

  // Next-state and register-update logic. Every _d defaults to its _q so
  // each state only spells out what it changes; first_d defaults low so
  // alg_start can only ever be a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = done_q;
    err_d   = err_q;
    zoom_d  = zoom_q;
    disp_d  = disp_q;
    sel_d   = sel_q;
    first_d = 1'b0;
    lat_d   = lat_q;
`ifdef ZOOM_CTRL_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          instr_d = instruction;
          addr_d  = addr_in;
          wdata_d = data_in;
          case (instruction)
            OP_NOP: begin
              done_d  = 1'b1;
              state_d = S_RELEASE;
            end
            OP_RESET: begin
              zoom_d  = Z_RST;
              disp_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_RELEASE;
            end
            OP_LOAD, OP_STORE: begin
              lat_d   = '0;
              state_d = S_MEM;
            end
            default: begin
              // Zoom request: reject at the bounds before any engine starts.
              if (((instruction == OP_ZIN_VP || instruction == OP_ZIN_RP) && zoom_q >= Z_MAX) ||
                  ((instruction == OP_ZOUT_MP || instruction == OP_ZOUT_VD) && zoom_q <= Z_MIN)) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_RELEASE;
              end else begin
                first_d = 1'b1;
`ifdef ZOOM_CTRL_WATCHDOG_EN
                wdog_d  = '0;
`endif
                case (instruction)
                  OP_ZIN_VP:  sel_d = 4'b0001;
                  OP_ZIN_RP:  sel_d = 4'b0010;
                  OP_ZOUT_MP: sel_d = 4'b0100;
                  default:    sel_d = 4'b1000;
                endcase
                state_d = S_ALG;
              end
            end
          endcase
        end
      end

      S_MEM: begin
        if (instr_q == OP_STORE) begin
          disp_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_RELEASE;
        end else if (lat_q == LAT_W'(MEM_LATENCY)) begin
          // mem_addr has been stable since the first MEM cycle, so the read
          // data is valid MEM_LATENCY cycles after that.
          dout_d  = mem_rdata;
          disp_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_RELEASE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_ALG: begin
        if (alg_done) begin
          zoom_d  = zoomInOp ? zoom_q + ZOOM_WIDTH'(1) : zoom_q - ZOOM_WIDTH'(1);
          disp_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_RELEASE;
        end
`ifdef ZOOM_CTRL_WATCHDOG_EN
        else if (wdog_q == 16'hFFFF) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_RELEASE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end

      S_RELEASE: begin
        // Returning to IDLE only once enable is low guarantees the host has
        // dropped its request before another one can be accepted.
        if (!enable) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          sel_d   = 4'b0000;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset also abandons any engine
  // run in progress, and a late alg_done is then ignored in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zoom_q  <= Z_RST;
      disp_q  <= 1'b0;
      sel_q   <= 4'b0000;
      first_q <= 1'b0;
      lat_q   <= '0;
`ifdef ZOOM_CTRL_WATCHDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      zoom_q  <= zoom_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      first_q <= first_d;
      lat_q   <= lat_d;
`ifdef ZOOM_CTRL_WATCHDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign data_out      = dout_q;
  assign flag_done     = done_q;
  assign flag_error    = err_q;
  assign busy          = (state_q != S_IDLE);
  assign current_zoom  = zoom_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  // STORE spends exactly one cycle in MEM, giving a single-cycle strobe.
  assign mem_wr        = (state_q == S_MEM) && (instr_q == OP_STORE);
  assign alg_sel       = sel_q;
  assign alg_start     = first_q;
  assign display_valid = disp_q;

endmodule

// File: tb/tb_zoom_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_zoom_ctrl_unit
//
// Purpose:
//   Self-checking bench for zoom_ctrl_unit. Directed requests push their
//   expected completion into a queue; a monitor pops and compares every time
//   flag_done rises. A small memory model with a 2-cycle read pipeline and
//   an engine responder answer the DUT's memory and alg_start activity.
// ---------------------------------------------------------------------------
module tb_zoom_ctrl_unit;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_STORE   = 3'b010;
  localparam logic [2:0] OP_ZIN_VP  = 3'b011;
  localparam logic [2:0] OP_ZIN_RP  = 3'b100;
  localparam logic [2:0] OP_ZOUT_MP = 3'b101;
  localparam logic [2:0] OP_ZOUT_VD = 3'b110;
  localparam logic [2:0] OP_RESET   = 3'b111;

  logic        clock;
  logic        reset;
  logic [2:0]  instruction;
  logic        enable;
  logic [18:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        flag_done;
  logic        flag_error;
  logic        busy;
  logic [2:0]  current_zoom;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic [3:0]  alg_sel;
  logic        alg_start;
  logic        alg_done;
  logic        display_valid;

  zoom_ctrl_unit dut (
    .clock         (clock),
    .reset         (reset),
    .instruction   (instruction),
    .enable        (enable),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .data_out      (data_out),
    .flag_done     (flag_done),
    .flag_error    (flag_error),
    .busy          (busy),
    .current_zoom  (current_zoom),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wr        (mem_wr),
    .mem_rdata     (mem_rdata),
    .alg_sel       (alg_sel),
    .alg_start     (alg_start),
    .alg_done      (alg_done),
    .display_valid (display_valid)
  );

  typedef struct {
    logic [7:0] dout;
    logic       err;
    logic [2:0] zoom;
    logic       disp;
    logic [3:0] sel;
  } resp_t;

  resp_t expQ[$];
  int    total = 0;
  int    bad   = 0;
  int    algDelay = -1;
  int    startCount = 0;
  int    wrCount = 0;
  logic [18:0] wrAddr;
  logic [7:0]  wrData;

  // Memory model: 256 bytes, two register stages on the read path.
  logic [7:0] mem [0:255];
  logic [7:0] pipe1, pipe2;
  logic       bdWe;
  logic [7:0] bdAddr, bdData;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bdWe) mem[bdAddr] <= bdData;
    else if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    pipe1 <= mem[mem_addr[7:0]];
    pipe2 <= pipe1;
  end
  assign mem_rdata = pipe2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectResp(input logic [7:0] dout, input logic err, input logic [2:0] zoom,
                            input logic disp, input logic [3:0] sel);
    resp_t r;
    r.dout = dout; r.err = err; r.zoom = zoom; r.disp = disp; r.sel = sel;
    expQ.push_back(r);
  endtask

  task automatic backdoorWrite(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    bdAddr = a; bdData = d; bdWe = 1'b1;
    @(negedge clock);
    bdWe = 1'b0;
  endtask

  // Issues one request, scrambles the inputs while busy, waits for done,
  // releases enable and checks the controller is idle one cycle later.
  task automatic applyStimulus(input logic [2:0] instr, input logic [18:0] addr,
                               input logic [7:0] data, input int delay, input int maxCycles);
    int n;
    algDelay = delay;
    startCount = 0;
    wrCount = 0;
    @(negedge clock);
    instruction = instr; addr_in = addr; data_in = data; enable = 1'b1;
    @(negedge clock);
    instruction = ~instr; addr_in = ~addr; data_in = ~data;
    n = 0;
    while (!flag_done && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    if (!flag_done) begin
      total++; bad++;
      $display("[TB] FAIL done_timeout: flag_done still 0 after %0d cycles, expected 1", maxCycles);
    end
    enable = 1'b0;
    @(negedge clock);
    checkOutput("busy_after_release", {31'd0, busy}, 32'd0);
    checkOutput("done_after_release", {31'd0, flag_done}, 32'd0);
  endtask

  // Monitor: compares each completion against the oldest expectation.
  initial begin
    logic prevDone;
    resp_t r;
    prevDone = 1'b0;
    forever begin
      @(negedge clock);
      if (flag_done && !prevDone) begin
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_done: flag_done rose with no request pending");
        end else begin
          r = expQ.pop_front();
          checkOutput("resp_data_out", {24'd0, data_out}, {24'd0, r.dout});
          checkOutput("resp_flag_error", {31'd0, flag_error}, {31'd0, r.err});
          checkOutput("resp_zoom", {29'd0, current_zoom}, {29'd0, r.zoom});
          checkOutput("resp_display_valid", {31'd0, display_valid}, {31'd0, r.disp});
          checkOutput("resp_alg_sel", {28'd0, alg_sel}, {28'd0, r.sel});
        end
      end
      prevDone = flag_done;
    end
  end

  // Engine responder: answers alg_start with an alg_done pulse algDelay
  // cycles later (0 = same cycle, negative = never).
  initial begin
    alg_done = 1'b0;
    forever begin
      @(negedge clock);
      if (alg_start) begin
        startCount++;
        if (algDelay >= 0) begin
          repeat (algDelay) @(negedge clock);
          alg_done = 1'b1;
          @(negedge clock);
          alg_done = 1'b0;
        end
      end
    end
  end

  // Write strobe watcher.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_wr) begin
        wrCount++;
        wrAddr = mem_addr;
        wrData = mem_wdata;
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("rst_flag_done", {31'd0, flag_done}, 32'd0);
    checkOutput("rst_flag_error", {31'd0, flag_error}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_zoom", {29'd0, current_zoom}, 32'd4);
    checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst_alg_sel", {28'd0, alg_sel}, 32'd0);
    checkOutput("rst_alg_start", {31'd0, alg_start}, 32'd0);
    checkOutput("rst_display_valid", {31'd0, display_valid}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; instruction = OP_NOP;
    addr_in = '0; data_in = '0; bdWe = 1'b0; bdAddr = '0; bdData = '0;
    repeat (3) @(negedge clock);
    checkResetState();
    reset = 1'b0;

    backdoorWrite(8'h20, 8'h5A);

    // STORE: single strobe with the latched address/data.
    expectResp(8'h00, 1'b0, 3'd4, 1'b1, 4'b0000);
    applyStimulus(OP_STORE, 19'h00010, 8'hA5, 0, 20);
    checkOutput("store_wr_count", wrCount, 32'd1);
    checkOutput("store_wr_addr", {13'd0, wrAddr}, 32'h10);
    checkOutput("store_wr_data", {24'd0, wrData}, 32'hA5);

    // LOAD of a different address: stale pipeline data must not be taken.
    expectResp(8'h5A, 1'b0, 3'd4, 1'b1, 4'b0000);
    applyStimulus(OP_LOAD, 19'h00020, 8'h00, 0, 20);
    checkOutput("load_no_write", wrCount, 32'd0);

    backdoorWrite(8'h10, 8'h3C);
    expectResp(8'h3C, 1'b0, 3'd4, 1'b1, 4'b0000);
    applyStimulus(OP_LOAD, 19'h00010, 8'h00, 0, 20);

    // NOP keeps data_out.
    expectResp(8'h3C, 1'b0, 3'd4, 1'b1, 4'b0000);
    applyStimulus(OP_NOP, 19'h0, 8'h00, 0, 20);

    // Zoom in via RP with a 10-cycle engine.
    expectResp(8'h3C, 1'b0, 3'd5, 1'b1, 4'b0010);
    applyStimulus(OP_ZIN_RP, 19'h0, 8'h00, 10, 40);
    checkOutput("rp_start_count", startCount, 32'd1);

    // RESET instruction.
    expectResp(8'h3C, 1'b0, 3'd4, 1'b0, 4'b0000);
    applyStimulus(OP_RESET, 19'h0, 8'h00, 0, 20);

    // Zoom out down to the lower bound, then reject.
    for (int i = 0; i < 3; i++) begin
      expectResp(8'h3C, 1'b0, 3'(3 - i), 1'b1, 4'b0100);
      applyStimulus(OP_ZOUT_MP, 19'h0, 8'h00, 3, 40);
    end
    expectResp(8'h3C, 1'b1, 3'd1, 1'b1, 4'b0000);
    applyStimulus(OP_ZOUT_MP, 19'h0, 8'h00, 3, 40);
    checkOutput("mp_reject_no_start", startCount, 32'd0);
    expectResp(8'h3C, 1'b1, 3'd1, 1'b1, 4'b0000);
    applyStimulus(OP_ZOUT_VD, 19'h0, 8'h00, 3, 40);

    // alg_done in the same cycle as alg_start.
    expectResp(8'h3C, 1'b0, 3'd2, 1'b1, 4'b0001);
    applyStimulus(OP_ZIN_VP, 19'h0, 8'h00, 0, 40);
    checkOutput("vp_same_cycle_start", startCount, 32'd1);

    // Zoom in up to the upper bound, then reject.
    for (int i = 0; i < 5; i++) begin
      expectResp(8'h3C, 1'b0, 3'(3 + i), 1'b1, 4'b0001);
      applyStimulus(OP_ZIN_VP, 19'h0, 8'h00, 1, 40);
    end
    expectResp(8'h3C, 1'b1, 3'd7, 1'b1, 4'b0000);
    applyStimulus(OP_ZIN_RP, 19'h0, 8'h00, 1, 40);
    checkOutput("rp_reject_no_start", startCount, 32'd0);

    // Reset during ALG, then a stray alg_done.
    algDelay = -1;
    @(negedge clock);
    instruction = OP_ZOUT_VD; enable = 1'b1;
    n = 0;
    while (!alg_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("abort_alg_start", {31'd0, alg_start}, 32'd1);
    checkOutput("abort_alg_sel", {28'd0, alg_sel}, 32'h8);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; enable = 1'b0; alg_done = 1'b1;
    @(negedge clock);
    alg_done = 1'b0;
    @(negedge clock);
    checkResetState();

    expectResp(8'h00, 1'b0, 3'd5, 1'b1, 4'b0010);
    applyStimulus(OP_ZIN_RP, 19'h0, 8'h00, 2, 40);

`ifdef ZOOM_CTRL_WATCHDOG_EN
    expectResp(8'h00, 1'b1, 3'd5, 1'b1, 4'b1000);
    applyStimulus(OP_ZOUT_VD, 19'h0, 8'h00, -1, 70000);
    checkOutput("wdog_start_count", startCount, 32'd1);
`endif

    repeat (2) @(negedge clock);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zoom_ctrl_unit.md
Name: zoom_ctrl_unit

Overview:
- Parametrised instruction sequencer for the image-zoom coprocessor.
- Accepts 3-bit instructions over a level enable/done handshake and performs LOAD/STORE accesses on the image memory.
- Launches one of four zoom engines (VP, RP, MP, VD) and tracks the current zoom level within configurable bounds.
- Sits between the host-facing pins and the memory/engine/VGA datapath.

Parameters:
- ADDR_WIDTH, 19: memory address width.
- DATA_WIDTH, 8: pixel width.
- ZOOM_WIDTH, 3: zoom level register width.
- ZOOM_MIN, 1: lowest legal zoom level.
- ZOOM_MAX, 7: highest legal zoom level.
- ZOOM_RESET, 4: level after reset or the RESET instruction (unity scale).
- MEM_LATENCY, 2: clock cycles from mem_addr valid to mem_rdata valid (at least 1).

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- instruction  in  3  000 NOP, 001 LOAD, 010 STORE, 011 ZOOM_IN_VP, 100 ZOOM_IN_RP, 101 ZOOM_OUT_MP, 110 ZOOM_OUT_VD, 111 RESET
- enable  in  1  host request, level
- addr_in  in  ADDR_WIDTH  host address for LOAD/STORE
- data_in  in  DATA_WIDTH  host write data
- data_out  out  DATA_WIDTH  LOAD result, held until the next LOAD
- flag_done  out  1  high while the completed request awaits release
- flag_error  out  1  request rejected; valid while flag_done is high
- busy  out  1  high in any state except IDLE
- current_zoom  out  ZOOM_WIDTH  current zoom level
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wr  out  1  one-cycle write strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- alg_sel  out  4  one-hot engine select {VD,MP,RP,VP}
- alg_start  out  1  one-cycle engine launch
- alg_done  in  1  engine completion pulse
- display_valid  out  1  VGA may show memory contents

Behaviour:
Reset values (synchronous reset, also applies mid-operation):
- state=IDLE; all outputs 0, except current_zoom=ZOOM_RESET.
- An engine already started is abandoned; its later alg_done is ignored in IDLE.

IDLE:
- Request accepted when enable=1. instruction and addr_in/data_in are latched in the same cycle.
- NOP: go to RELEASE, flag_done set the next cycle.
- RESET instr: current_zoom<=ZOOM_RESET, display_valid<=0, go to RELEASE.
- LOAD/STORE: go to MEM.
- Zoom-in with current_zoom>=ZOOM_MAX, or zoom-out with current_zoom<=ZOOM_MIN: flag_error<=1, go to RELEASE. No engine start, no zoom change.
- Other zoom instructions: go to ALG.

MEM:
- STORE: mem_addr/mem_wdata driven and mem_wr=1 for exactly one cycle, then RELEASE.
- LOAD: mem_addr driven, MEM_LATENCY-cycle counter runs; on expiry data_out<=mem_rdata, then RELEASE.
- Any completed LOAD or STORE sets display_valid=1.

ALG:
- First cycle: alg_start=1, alg_sel one-hot per instruction (VP=0001, RP=0010, MP=0100, VD=1000). alg_sel holds until release.
- Wait for alg_done, then current_zoom +1 for zoom-in or -1 for zoom-out, display_valid<=1, go to RELEASE.
- alg_done arriving in the same cycle as alg_start is honoured.

RELEASE:
- flag_done=1. Wait for enable=0, then clear flag_done/flag_error/alg_sel and return to IDLE.
- No new request is accepted until enable has been low for at least one cycle.

Invariants:
- Instruction inputs changing while busy are ignored.
- current_zoom never leaves [ZOOM_MIN, ZOOM_MAX].

Optional Feature:
- ZOOM_CTRL_WATCHDOG_EN defined:
  - A 16-bit counter runs in ALG.
  - If alg_done is absent 65535 cycles after alg_start, flag_error=1, current_zoom is unchanged, and the block goes to RELEASE.
- Undefined: ALG waits indefinitely for alg_done; no counter is synthesised.

Test Plan:
- Reset, then STORE addr 0x00010 data 0xA5 -> one mem_wr pulse with mem_addr=0x00010, mem_wdata=0xA5; flag_done=1; display_valid=1.
- LOAD addr 0x00010 with mem_rdata=0x3C after 2 cycles -> data_out=0x3C; flag_done high until enable drops, then busy=0 one cycle later.
- ZOOM_IN_RP from level 4, alg_done 10 cycles later -> alg_sel=0010, single alg_start pulse, current_zoom=5.
- Three ZOOM_OUT_MP from level 4 with ZOOM_MIN=1, then a fourth -> levels 3, 2, 1; the fourth gives flag_error=1, no alg_start, level stays 1.
- Assert reset during ALG, then raise alg_done -> state IDLE, current_zoom=4, all outputs 0; the stray alg_done has no effect.
- With ZOOM_CTRL_WATCHDOG_EN, start ZOOM_OUT_VD and never raise alg_done -> flag_error=1 and flag_done=1 at cycle 65535, level unchanged.
